sample_sink_fifo: RTL

Downstream consumer of the data_out/valid stream produced by the 8-bit datapath stage. It captures every cycle in which in_valid is high into a show-ahead FIFO, which absorbs bursts until a ready/valid consumer drains them. It also keeps sticky overflow status, a saturating accepted-sample count and a running XOR checksum for debug and self-check.

---
 rtl/sample_sink_fifo.sv | 91 +++++++++
 1 files changed

// File: rtl/sample_sink_fifo.sv
// Show-ahead sample FIFO for the 8-bit datapath output stream.
// It also keeps sticky overflow status, a saturating sample count and an XOR checksum.
module sample_sink_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     in_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [CNT_W-1:0]         sample_count,
   output logic [DATA_W-1:0]        checksum
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]         r_wr_ptr;
   logic [AW:0]         r_rd_ptr;
   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [DATA_W-1:0]   r_last;
   logic                r_overflow;
   logic [CNT_W-1:0]    r_count;
   logic [DATA_W-1:0]   r_checksum;

   logic                w_empty;
   logic                w_full;
   logic                w_pop;
   logic                w_push;
   logic                w_drop;
   logic                w_flush;
   logic [DATA_W-1:0]   w_head;

   assign w_flush = rst | clear;
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                    (r_wr_ptr[AW] != r_rd_ptr[AW]);
   assign w_pop   = !w_empty && out_ready;
   assign w_push  = in_valid && (!w_full || w_pop);
   assign w_drop  = in_valid && w_full && !w_pop;
   assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

   // While empty, present the most recent head rather than stale memory.
   assign out_data     = w_empty ? r_last : w_head;
   assign out_valid    = !w_empty;
   assign level        = r_wr_ptr - r_rd_ptr;
   assign overflow     = r_overflow;
   assign sample_count = r_count;
   assign checksum     = r_checksum;

   always_ff @(posedge clk) begin
      if (!w_flush && w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (w_flush) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_last     <= '0;
         r_overflow <= 1'b0;
         r_count    <= '0;
         r_checksum <= '0;
      end else begin
         if (!w_empty) begin
            r_last <= w_head;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push) begin
            r_wr_ptr   <= r_wr_ptr + 1'b1;
            r_checksum <= r_checksum ^ in_data;
            if (r_count != {CNT_W{1'b1}}) begin
               r_count <= r_count + 1'b1;
            end
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

endmodule
